// File: rtl/ahb_arb_pkg.sv
// Shared types and helpers for the AHB round-robin arbiter.
// The slave response encoding and a one-hot to index converter sized for the largest bus.
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        OKAY  = 2'b00,
        ERROR = 2'b01,
        RETRY = 2'b10,
        SPLIT = 2'b11
    } hresp_t;

    localparam int MAX_MASTERS = 16;
    localparam int MAX_IDX_W   = $clog2(MAX_MASTERS);

    // Callers zero-extend narrower grant vectors and truncate the result to their own index width.
    function automatic logic [MAX_IDX_W-1:0] onehot2idx(input logic [MAX_MASTERS-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (oh[i]) begin
                idx = idx | MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ahb_arb_pick.sv
// Combinational request picker: round-robin starting after last_idx, or lowest index first.
// Returns a one-hot pick plus a flag saying whether any request was present.
module ahb_arb_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_idx,
    input  logic             rr_en,
    output logic [N-1:0]     pick,
    output logic             valid
);

    logic [IDX_W:0] start;
    logic [N-1:0]   rot;
    logic [N-1:0]   rot_oh;
    logic [N-1:0]   pick_rr;
    logic [N-1:0]   pick_fixed;

    // Rotate so last_idx+1 sits at bit 0, take the lowest set bit, then rotate back.
    always_comb begin
        start      = {1'b0, last_idx} + (IDX_W+1)'(1);
        rot        = N'({req, req} >> start);
        rot_oh     = rot & (~rot + N'(1));
        pick_rr    = N'(({rot_oh, rot_oh} << start) >> N);
        pick_fixed = req & (~req + N'(1));
        pick       = rr_en ? pick_rr : pick_fixed;
        valid      = |req;
    end

endmodule

// File: rtl/ahb_arbiter_rr.sv
// AHB bus arbiter with round-robin or fixed priority, locked-transfer hold,
// split masking and a bounded grant tenure for non-locked owners.
module ahb_arbiter_rr
    import ahb_arb_pkg::*;
#(
    parameter int N_MASTERS      = 16,
    parameter bit RR_EN          = 1'b1,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_HOLD       = 8
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic [N_MASTERS-1:0]         HBUSREQx,
    input  logic [N_MASTERS-1:0]         HLOCKx,
    input  logic [N_MASTERS-1:0]         HSPLIT,
    input  logic                         HREADY,
    input  hresp_t                       HRESP,
    output logic [N_MASTERS-1:0]         HGRANTx,
    output logic [$clog2(N_MASTERS)-1:0] HMASTER,
    output logic                         HMASTLOCK
);

    localparam int IDX_W = $clog2(N_MASTERS);
    localparam int CNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);
    localparam logic [N_MASTERS-1:0] DEFAULT_OH  = N_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [IDX_W-1:0]     DEFAULT_IDX = IDX_W'(DEFAULT_MASTER);

    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]     master_q, master_d;
    logic                 mastlock_q, mastlock_d;
    logic [N_MASTERS-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic [IDX_W-1:0]     owner_idx;
    logic [N_MASTERS-1:0] eligible;
    logic [N_MASTERS-1:0] others;
    logic [N_MASTERS-1:0] pick_oh;
    logic                 others_any;
    logic                 hold_ok;

    ahb_arb_pick #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req      (others),
        .last_idx (rr_ptr_q),
        .rr_en    (RR_EN),
        .pick     (pick_oh),
        .valid    (others_any)
    );

    always_comb begin
        owner_idx = IDX_W'(onehot2idx(MAX_MASTERS'(grant_q)));
        eligible  = HBUSREQx & ~mask_q;
        others    = eligible & ~grant_q;
        hold_ok   = (MAX_HOLD == 0) || (int'(hold_cnt_q) < MAX_HOLD - 1);

        grant_d    = grant_q;
        hold_cnt_d = hold_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        master_d   = master_q;
        mastlock_d = mastlock_q;

        if (HREADY) begin
            master_d   = owner_idx;
            mastlock_d = HLOCKx[owner_idx];
            // Lock beats everything, including an expired hold limit or a split mask.
            if (HLOCKx[owner_idx] && HBUSREQx[owner_idx]) begin
                grant_d = grant_q;
            end else if (eligible[owner_idx] && (!others_any || hold_ok)) begin
                if (others_any && (hold_cnt_q != '1)) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end else if (others_any) begin
                grant_d    = pick_oh;
                hold_cnt_d = '0;
            end else begin
                grant_d    = DEFAULT_OH;
                hold_cnt_d = '0;
            end
            if (grant_d != grant_q) begin
                rr_ptr_d = IDX_W'(onehot2idx(MAX_MASTERS'(grant_d)));
            end
        end
    end

    // Split clears are unqualified; a set on the same bit in the same cycle still wins.
    always_comb begin
        mask_d = mask_q & ~HSPLIT;
        if (HREADY && (HRESP == SPLIT)) begin
            mask_d[master_q] = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_q    <= DEFAULT_OH;
            master_q   <= DEFAULT_IDX;
            mastlock_q <= 1'b0;
            mask_q     <= '0;
            hold_cnt_q <= '0;
            rr_ptr_q   <= DEFAULT_IDX;
        end else begin
            grant_q    <= grant_d;
            master_q   <= master_d;
            mastlock_q <= mastlock_d;
            mask_q     <= mask_d;
            hold_cnt_q <= hold_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign HGRANTx   = grant_q;
    assign HMASTER   = master_q;
    assign HMASTLOCK = mastlock_q;

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// Directed bench for ahb_arbiter_rr: four masters, hold limit 3, with a round-robin
// instance and a fixed-priority instance driven from the same inputs.
module tb_ahb_arbiter_rr;
    import ahb_arb_pkg::*;

    localparam int N = 4;

    logic         HCLK;
    logic         HRESETn;
    logic [N-1:0] HBUSREQx;
    logic [N-1:0] HLOCKx;
    logic [N-1:0] HSPLIT;
    logic         HREADY;
    hresp_t       HRESP;

    logic [N-1:0] grantRr, grantFp;
    logic [1:0]   masterRr, masterFp;
    logic         lockRr, lockFp;

    int vecCount  = 0;
    int failCount = 0;

    int rrSeq[10] = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 1};
    int fpSeq[10] = '{1, 1, 1, 2, 2, 2, 1, 1, 1, 2};
    int splitSeq[3] = '{2, 2, 1};

    ahb_arbiter_rr #(
        .N_MASTERS      (N),
        .RR_EN          (1'b1),
        .DEFAULT_MASTER (0),
        .MAX_HOLD       (3)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HBUSREQx  (HBUSREQx),
        .HLOCKx    (HLOCKx),
        .HSPLIT    (HSPLIT),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .HGRANTx   (grantRr),
        .HMASTER   (masterRr),
        .HMASTLOCK (lockRr)
    );

    ahb_arbiter_rr #(
        .N_MASTERS      (N),
        .RR_EN          (1'b0),
        .DEFAULT_MASTER (0),
        .MAX_HOLD       (3)
    ) dutFp (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HBUSREQx  (HBUSREQx),
        .HLOCKx    (HLOCKx),
        .HSPLIT    (HSPLIT),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .HGRANTx   (grantFp),
        .HMASTER   (masterFp),
        .HMASTLOCK (lockFp)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] req, input logic [N-1:0] lock,
                                 input logic rdy, input hresp_t resp, input logic [N-1:0] split);
        HBUSREQx = req;
        HLOCKx   = lock;
        HREADY   = rdy;
        HRESP    = resp;
        HSPLIT   = split;
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic checkState(input string tag, input int gIdx, input int mIdx, input logic lk);
        logic [N-1:0] expOh;
        expOh = N'(1) << gIdx;
        checkOutput({tag, " grant"}, 32'(grantRr), 32'(expOh));
        checkOutput({tag, " master"}, 32'(masterRr), 32'(mIdx));
        checkOutput({tag, " lock"}, 32'(lockRr), 32'(lk));
        checkOutput({tag, " onehot"}, 32'($countones(grantRr)), 32'd1);
    endtask

    task automatic doReset();
        @(posedge HCLK);
        #1;
        applyStimulus(4'b0000, 4'b0000, 1'b1, OKAY, 4'b0000);
        HRESETn = 1'b0;
        #3;
        HRESETn = 1'b1;
    endtask

    initial begin
        HRESETn = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 1'b1, OKAY, 4'b0000);

        // Reset and idle bus: default master parked.
        doReset();
        checkState("reset", 0, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkState("idle", 0, 0, 1'b0);
        end

        // Three requesters, hold limit forces rotation.
        doReset();
        applyStimulus(4'b1110, 4'b0000, 1'b1, OKAY, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("rr seq", 32'(grantRr), 32'(N'(1) << rrSeq[i]));
            checkOutput("fp seq", 32'(grantFp), 32'(N'(1) << fpSeq[i]));
        end

        // Locked owner keeps the bus past the hold limit.
        doReset();
        applyStimulus(4'b0100, 4'b0000, 1'b1, OKAY, 4'b0000);
        tick();
        checkState("lock setup", 2, 0, 1'b0);
        applyStimulus(4'b1111, 4'b0100, 1'b1, OKAY, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkState("locked", 2, 2, 1'b1);
        end

        // Split masks master 1 until HSPLIT releases it.
        doReset();
        applyStimulus(4'b0010, 4'b0000, 1'b1, OKAY, 4'b0000);
        tick();
        tick();
        checkState("split setup", 1, 1, 1'b0);
        applyStimulus(4'b0110, 4'b0000, 1'b1, SPLIT, 4'b0000);
        tick();
        checkState("split edge", 1, 1, 1'b0);
        applyStimulus(4'b0110, 4'b0000, 1'b1, OKAY, 4'b0000);
        tick();
        checkState("split moved", 2, 1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkState("masked", 2, 2, 1'b0);
        end
        applyStimulus(4'b0110, 4'b0000, 1'b1, OKAY, 4'b0010);
        tick();
        checkState("hsplit edge", 2, 2, 1'b0);
        applyStimulus(4'b0110, 4'b0000, 1'b1, OKAY, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("unmasked seq", 32'(grantRr), 32'(N'(1) << splitSeq[i]));
        end

        // Wait states freeze everything; first ready edge arbitrates.
        doReset();
        applyStimulus(4'b0010, 4'b0000, 1'b1, OKAY, 4'b0000);
        tick();
        tick();
        checkState("wait setup", 1, 1, 1'b0);
        applyStimulus(4'b1000, 4'b0010, 1'b0, SPLIT, 4'b0000);
        tick();
        checkState("wait 1", 1, 1, 1'b0);
        applyStimulus(4'b0100, 4'b1111, 1'b0, OKAY, 4'b0000);
        tick();
        checkState("wait 2", 1, 1, 1'b0);
        applyStimulus(4'b0001, 4'b0000, 1'b0, RETRY, 4'b0000);
        tick();
        checkState("wait 3", 1, 1, 1'b0);
        applyStimulus(4'b1111, 4'b0000, 1'b0, ERROR, 4'b0000);
        tick();
        checkState("wait 4", 1, 1, 1'b0);
        applyStimulus(4'b1100, 4'b0000, 1'b1, OKAY, 4'b0000);
        tick();
        checkState("ready edge", 2, 1, 1'b0);

        // Asynchronous reset during a locked transfer by master 3.
        doReset();
        applyStimulus(4'b0010, 4'b0000, 1'b1, OKAY, 4'b0000);
        tick();
        tick();
        applyStimulus(4'b0010, 4'b0000, 1'b1, SPLIT, 4'b0000);
        tick();
        applyStimulus(4'b1000, 4'b1000, 1'b1, OKAY, 4'b0000);
        tick();
        checkState("lock3 grant", 3, 1, 1'b0);
        tick();
        checkState("lock3 owned", 3, 3, 1'b1);
        #2;
        HRESETn = 1'b0;
        #1;
        checkState("async reset", 0, 0, 1'b0);
        #1;
        HRESETn = 1'b1;
        applyStimulus(4'b0010, 4'b0000, 1'b1, OKAY, 4'b0000);
        tick();
        checkState("mask cleared", 1, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
